// File: rtl/tcm_sram_2p_if.sv
// Request/response bundle for the two-port TCM SRAM.
// Port A is read/write with byte-lane masks; port B is read-only.
interface tcm_sram_2p_if #(
   parameter int DW = 32,
   parameter int MW = (DW + 7) / 8,
   parameter int AW = 9
);
   logic          init_done;

   logic          a_cs;
   logic          a_we;
   logic [MW-1:0] a_wem;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic [DW-1:0] a_dout;
   logic          a_rvalid;
   logic          a_err;

   logic          b_cs;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_dout;
   logic          b_rvalid;
   logic          b_err;

   modport master (
      input  init_done,
      output a_cs, a_we, a_wem, a_addr, a_din,
      input  a_dout, a_rvalid, a_err,
      output b_cs, b_addr,
      input  b_dout, b_rvalid, b_err
   );

   modport slave (
      output init_done,
      input  a_cs, a_we, a_wem, a_addr, a_din,
      output a_dout, a_rvalid, a_err,
      input  b_cs, b_addr,
      output b_dout, b_rvalid, b_err
   );
endinterface

// File: rtl/tcm_sram_2p.sv
// Two-port TCM SRAM model: port A read/write with byte lanes, port B read-only,
// 1- or 2-cycle read latency, range checking and an optional zero-init sweep.
module tcm_sram_2p #(
   parameter int DP           = 512,
   parameter int DW           = 32,
   parameter int MW           = (DW + 7) / 8,
   parameter int AW           = 9,
   parameter int RD_LAT       = 1,
   parameter int WR_BYPASS    = 0,
   parameter int INIT_ZERO    = 0,
   parameter int FORCE_X2ZERO = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   tcm_sram_2p_if.slave bus
);

   localparam int            IW   = (DP > 1) ? $clog2(DP) : 1;
   localparam logic [AW:0]   DP_L = (AW + 1)'(DP);

   typedef enum logic [1:0] {ST_RST, ST_SWEEP, ST_READY} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic            sweep_we;
   logic            init_done;

   logic [DW-1:0]   mem_q [DP];

   logic            a_in_rng, b_in_rng;
   logic [IW-1:0]   a_idx, b_idx;
   logic            a_rd, a_wr_ok, a_werr, b_rd;
   logic [DW-1:0]   wr_mask;
   logic [DW-1:0]   a_rdata, b_word, b_rdata;

   logic            a_v1_q, a_e1_q, a_werr_q, b_v1_q, b_e1_q;
   logic [DW-1:0]   a_d1_q, b_d1_q;

   logic            a_rv, a_re, b_rv, b_re;
   logic [DW-1:0]   a_dout_raw, b_dout_raw, a_dout_fx, b_dout_fx;

   // ------------------------------------------------------------------
   // Init sweep FSM. The first edge after reset release already clears
   // word 0, so READY is reached exactly DP edges after release.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (INIT_ZERO != 0) ? ST_RST : ST_READY;
         cnt_q   <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      sweep_we = 1'b0;
      unique case (state_q)
         ST_RST: begin
            sweep_we = 1'b1;
            cnt_d    = IW'(1);
            state_d  = (DP == 1) ? ST_READY : ST_SWEEP;
         end
         ST_SWEEP: begin
            sweep_we = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == IW'(DP - 1)) state_d = ST_READY;
         end
         ST_READY: ;
         default: state_d = ST_READY;
      endcase
   end

   assign init_done = (state_q == ST_READY);

   // ------------------------------------------------------------------
   // Request decode: out-of-range addresses are flagged, never wrapped.
   // ------------------------------------------------------------------
   assign a_in_rng = ({1'b0, bus.a_addr} < DP_L);
   assign b_in_rng = ({1'b0, bus.b_addr} < DP_L);
   assign a_idx    = bus.a_addr[IW-1:0];
   assign b_idx    = bus.b_addr[IW-1:0];

   assign a_rd     = init_done & bus.a_cs & ~bus.a_we;
   assign a_wr_ok  = init_done & bus.a_cs &  bus.a_we &  a_in_rng;
   assign a_werr   = init_done & bus.a_cs &  bus.a_we & ~a_in_rng;
   assign b_rd     = init_done & bus.b_cs;

   // Expand byte enables to a bit mask; the top lane may be narrower than 8.
   for (genvar g = 0; g < MW; g++) begin : g_lane
      localparam int LO = 8 * g;
      localparam int HI = (8 * g + 7 < DW) ? 8 * g + 7 : DW - 1;
      assign wr_mask[HI:LO] = {(HI - LO + 1){bus.a_wem[g]}};
   end

   assign a_rdata = a_in_rng ? mem_q[a_idx] : '0;
   assign b_word  = b_in_rng ? mem_q[b_idx] : '0;

   always_comb begin
      b_rdata = b_word;
      if (WR_BYPASS != 0 && a_wr_ok && bus.a_addr == bus.b_addr)
         b_rdata = (b_word & ~wr_mask) | (bus.a_din & wr_mask);
   end

   // ------------------------------------------------------------------
   // Storage. Sweep and port A writes are exclusive: A is gated by init_done.
   // ------------------------------------------------------------------
   // NOTE: the array deliberately has no reset, so it maps onto plain SRAM macros.
   always_ff @(posedge clk) begin
      if (sweep_we)
         mem_q[cnt_q] <= '0;
      else if (a_wr_ok)
         mem_q[a_idx] <= (mem_q[a_idx] & ~wr_mask) | (bus.a_din & wr_mask);
   end

   // ------------------------------------------------------------------
   // First read stage. Data registers load only on a read, so dout holds.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_v1_q   <= 1'b0;
         a_e1_q   <= 1'b0;
         a_d1_q   <= '0;
         a_werr_q <= 1'b0;
         b_v1_q   <= 1'b0;
         b_e1_q   <= 1'b0;
         b_d1_q   <= '0;
      end else begin
         a_v1_q   <= a_rd;
         a_e1_q   <= a_rd & ~a_in_rng;
         a_werr_q <= a_werr;
         b_v1_q   <= b_rd;
         b_e1_q   <= b_rd & ~b_in_rng;
         if (a_rd) a_d1_q <= a_rdata;
         if (b_rd) b_d1_q <= b_rdata;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic          a_v2_q, a_e2_q, b_v2_q, b_e2_q;
      logic [DW-1:0] a_d2_q, b_d2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_v2_q <= 1'b0;
            a_e2_q <= 1'b0;
            a_d2_q <= '0;
            b_v2_q <= 1'b0;
            b_e2_q <= 1'b0;
            b_d2_q <= '0;
         end else begin
            a_v2_q <= a_v1_q;
            a_e2_q <= a_e1_q;
            b_v2_q <= b_v1_q;
            b_e2_q <= b_e1_q;
            if (a_v1_q) a_d2_q <= a_d1_q;
            if (b_v1_q) b_d2_q <= b_d1_q;
         end
      end

      assign a_rv       = a_v2_q;
      assign a_re       = a_e2_q;
      assign a_dout_raw = a_d2_q;
      assign b_rv       = b_v2_q;
      assign b_re       = b_e2_q;
      assign b_dout_raw = b_d2_q;
   end else begin : g_lat1
      assign a_rv       = a_v1_q;
      assign a_re       = a_e1_q;
      assign a_dout_raw = a_d1_q;
      assign b_rv       = b_v1_q;
      assign b_re       = b_e1_q;
      assign b_dout_raw = b_d1_q;
   end

   // Simulation-only X scrubbing of read data; synthesis sees a wire.
`ifdef SYNTHESIS
   assign a_dout_fx = a_dout_raw;
   assign b_dout_fx = b_dout_raw;
`else
   always_comb begin
      a_dout_fx = a_dout_raw;
      b_dout_fx = b_dout_raw;
      if (FORCE_X2ZERO != 0) begin
         for (int i = 0; i < DW; i++) begin
            if ($isunknown(a_dout_raw[i])) a_dout_fx[i] = 1'b0;
            if ($isunknown(b_dout_raw[i])) b_dout_fx[i] = 1'b0;
         end
      end
   end
`endif

   assign bus.init_done = init_done;
   assign bus.a_dout    = a_dout_fx;
   assign bus.a_rvalid  = a_rv;
   assign bus.a_err     = a_re | a_werr_q;
   assign bus.b_dout    = b_dout_fx;
   assign bus.b_rvalid  = b_rv;
   assign bus.b_err     = b_re;

endmodule

// File: tb/tb_tcm_sram_2p.sv
// Bench for tcm_sram_2p: a small zero-init instance (RD_LAT=1, bypass) and a
// large instance (RD_LAT=2, no bypass), each scored against a reference model.
module tb_tcm_sram_2p;

   localparam int DP_X = 16,  LAT_X = 1;
   localparam bit BYP_X = 1'b1;
   localparam int DP_Y = 500, LAT_Y = 2;
   localparam bit BYP_Y = 1'b0;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      bit          err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n_x, rst_n_y;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [31:0] mdl [2][512];
   exp_t qxa[$], qxb[$], qya[$], qyb[$];

   tcm_sram_2p_if #(.DW(32), .MW(4), .AW(5)) ifx ();
   tcm_sram_2p_if #(.DW(32), .MW(4), .AW(9)) ify ();

   tcm_sram_2p #(
      .DP(DP_X), .DW(32), .MW(4), .AW(5), .RD_LAT(LAT_X),
      .WR_BYPASS(1), .INIT_ZERO(1), .FORCE_X2ZERO(0)
   ) u_x (
      .clk   (clk),
      .rst_n (rst_n_x),
      .bus   (ifx)
   );

   tcm_sram_2p #(
      .DP(DP_Y), .DW(32), .MW(4), .AW(9), .RD_LAT(LAT_Y),
      .WR_BYPASS(0), .INIT_ZERO(0), .FORCE_X2ZERO(1)
   ) u_y (
      .clk   (clk),
      .rst_n (rst_n_y),
      .bus   (ify)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cmp_evt(input string tag, input exp_t e, input logic rv,
                          input logic er, input logic [31:0] d);
      check({tag, "_rvalid"}, {31'b0, rv}, {31'b0, e.is_rd});
      check({tag, "_err"},    {31'b0, er}, {31'b0, e.err});
      if (e.is_rd) check({tag, "_data"}, d, e.data);
   endtask

   // Scoreboard monitors: an entry must show up exactly on its due cycle.
   always @(negedge clk) if (rst_n_x) begin
      if (qxa.size() != 0 && qxa[0].due == cyc)
         cmp_evt("x_a", qxa.pop_front(), ifx.a_rvalid, ifx.a_err, ifx.a_dout);
      else if (ifx.a_rvalid || ifx.a_err)
         check("x_a_spurious", {30'b0, ifx.a_rvalid, ifx.a_err}, 32'h0);
      if (qxb.size() != 0 && qxb[0].due == cyc)
         cmp_evt("x_b", qxb.pop_front(), ifx.b_rvalid, ifx.b_err, ifx.b_dout);
      else if (ifx.b_rvalid || ifx.b_err)
         check("x_b_spurious", {30'b0, ifx.b_rvalid, ifx.b_err}, 32'h0);
   end

   always @(negedge clk) if (rst_n_y) begin
      if (qya.size() != 0 && qya[0].due == cyc)
         cmp_evt("y_a", qya.pop_front(), ify.a_rvalid, ify.a_err, ify.a_dout);
      else if (ify.a_rvalid || ify.a_err)
         check("y_a_spurious", {30'b0, ify.a_rvalid, ify.a_err}, 32'h0);
      if (qyb.size() != 0 && qyb[0].due == cyc)
         cmp_evt("y_b", qyb.pop_front(), ify.b_rvalid, ify.b_err, ify.b_dout);
      else if (ify.b_rvalid || ify.b_err)
         check("y_b_spurious", {30'b0, ify.b_rvalid, ify.b_err}, 32'h0);
   end

   task automatic push(input int id, input bit port_b, input exp_t e);
      if (id == 0) begin
         if (port_b) qxb.push_back(e); else qxa.push_back(e);
      end else begin
         if (port_b) qyb.push_back(e); else qya.push_back(e);
      end
   endtask

   // One cycle of stimulus on instance id (other instance idles), with model update.
   task automatic drive(input int id, input bit acs, input bit awe, input logic [3:0] wem,
                        input int aa, input logic [31:0] ad, input bit bcs, input int ba);
      int          dp, lat;
      bit          byp;
      exp_t        e;
      logic [31:0] merged, bval;
      dp  = (id == 0) ? DP_X  : DP_Y;
      lat = (id == 0) ? LAT_X : LAT_Y;
      byp = (id == 0) ? BYP_X : BYP_Y;
      ifx.a_cs = 1'b0; ifx.b_cs = 1'b0;
      ify.a_cs = 1'b0; ify.b_cs = 1'b0;
      if (id == 0) begin
         ifx.a_cs = acs; ifx.a_we = awe; ifx.a_wem = wem; ifx.a_addr = 5'(aa);
         ifx.a_din = ad; ifx.b_cs = bcs; ifx.b_addr = 5'(ba);
      end else begin
         ify.a_cs = acs; ify.a_we = awe; ify.a_wem = wem; ify.a_addr = 9'(aa);
         ify.a_din = ad; ify.b_cs = bcs; ify.b_addr = 9'(ba);
      end
      bval = (ba < dp) ? mdl[id][ba] : 32'h0;
      if (acs && awe) begin
         if (aa >= dp) begin
            e.is_rd = 1'b0; e.data = 32'h0; e.err = 1'b1; e.due = cyc + 1;
            push(id, 1'b0, e);
         end else begin
            merged = mdl[id][aa];
            for (int l = 0; l < 4; l++) if (wem[l]) merged[8*l +: 8] = ad[8*l +: 8];
            mdl[id][aa] = merged;
            if (byp && bcs && ba == aa) bval = merged;
         end
      end else if (acs) begin
         e.is_rd = 1'b1; e.data = (aa < dp) ? mdl[id][aa] : 32'h0;
         e.err = (aa >= dp); e.due = cyc + lat;
         push(id, 1'b0, e);
      end
      if (bcs) begin
         e.is_rd = 1'b1; e.data = bval; e.err = (ba >= dp); e.due = cyc + lat;
         push(id, 1'b1, e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int id, input int n);
      for (int k = 0; k < n; k++) drive(id, 1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0, 0);
   endtask

   initial begin
      ifx.a_cs = 1'b0; ifx.a_we = 1'b0; ifx.a_wem = '0; ifx.a_addr = '0; ifx.a_din = '0;
      ifx.b_cs = 1'b0; ifx.b_addr = '0;
      ify.a_cs = 1'b0; ify.a_we = 1'b0; ify.a_wem = '0; ify.a_addr = '0; ify.a_din = '0;
      ify.b_cs = 1'b0; ify.b_addr = '0;
      rst_n_x = 1'b0;
      rst_n_y = 1'b0;
      repeat (3) @(negedge clk);

      check("x_rst_a_dout", ifx.a_dout, 32'h0);
      check("x_rst_b_dout", ifx.b_dout, 32'h0);
      check("x_rst_flags", {28'b0, ifx.a_rvalid, ifx.a_err, ifx.b_rvalid, ifx.b_err}, 32'h0);
      check("x_rst_init_done", {31'b0, ifx.init_done}, 32'h0);
      check("y_rst_init_done", {31'b0, ify.init_done}, 32'h1);
      check("y_rst_dout", ify.a_dout | ify.b_dout, 32'h0);

      // Start the sweep, then interrupt it at cnt=7.
      rst_n_x = 1'b1;
      rst_n_y = 1'b1;
      repeat (7) @(negedge clk);
      check("x_mid_sweep_init", {31'b0, ifx.init_done}, 32'h0);
      rst_n_x = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_x = 1'b1;

      // Full sweep from word 0; a request late in the sweep must be ignored.
      repeat (10) @(negedge clk);
      ifx.a_cs = 1'b1; ifx.a_we = 1'b1; ifx.a_wem = 4'hF; ifx.a_addr = 5'd2;
      ifx.a_din = 32'hDEADBEEF; ifx.b_cs = 1'b1; ifx.b_addr = 5'd2;
      @(negedge clk);
      ifx.a_cs = 1'b0; ifx.b_cs = 1'b0;
      repeat (4) @(negedge clk);
      check("x_sweep_15_cycles", {31'b0, ifx.init_done}, 32'h0);
      @(negedge clk);
      check("x_sweep_16_cycles", {31'b0, ifx.init_done}, 32'h1);
      for (int i = 0; i < DP_X; i++) mdl[0][i] = 32'h0;

      // Zero-init contents and byte masks.
      drive(0, 1, 0, 4'h0, 2, 32'h0, 1, 15);
      drive(0, 1, 1, 4'hF, 3, 32'hAABBCCDD, 0, 0);
      drive(0, 1, 1, 4'h5, 3, 32'h11223344, 0, 0);
      drive(0, 1, 0, 4'h0, 3, 32'h0, 1, 3);
      drive(0, 1, 1, 4'hF, 4, 32'h12345678, 0, 0);
      idle(0, 2);
      check("x_a_dout_hold", ifx.a_dout, 32'hAA22CC44);
      check("x_b_dout_hold", ifx.b_dout, 32'hAA22CC44);

      // Read followed by a write to the same word returns the old word.
      drive(0, 1, 0, 4'h0, 3, 32'h0, 0, 0);
      drive(0, 1, 1, 4'hF, 3, 32'h5A5A5A5A, 0, 0);
      drive(0, 1, 0, 4'h0, 3, 32'h0, 0, 0);

      // Same-cycle collision with bypass: merged word on B.
      drive(0, 1, 1, 4'h3, 5, 32'hFFFFFFFF, 1, 5);
      drive(0, 1, 0, 4'h0, 5, 32'h0, 0, 0);

      // Range: first invalid address on B, beyond range on A, alias untouched.
      drive(0, 1, 0, 4'h0, 20, 32'h0, 1, 16);
      idle(0, 1);
      drive(0, 1, 1, 4'hF, 17, 32'hBAD0BAD0, 0, 0);
      idle(0, 1);
      drive(0, 1, 0, 4'h0, 1, 32'h0, 1, 15);
      idle(0, 3);

      // Large instance: fill, then stream on both ports.
      for (int i = 0; i < 8; i++) drive(1, 1, 1, 4'hF, i, 32'hC0DE0000 + 32'(i) * 32'h00010203, 0, 0);
      drive(1, 1, 1, 4'hF, 499, 32'h499F499F, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 1, 0, 4'h0, i, 32'h0, 1, 7 - i);
      idle(1, 3);
      check("y_a_dout_hold_last", ify.a_dout, mdl[1][7]);
      check("y_b_dout_hold_last", ify.b_dout, mdl[1][0]);

      drive(1, 1, 1, 4'hF, 3, 32'hAABBCCDD, 0, 0);
      drive(1, 1, 1, 4'h5, 3, 32'h11223344, 0, 0);
      drive(1, 1, 0, 4'h0, 3, 32'h0, 0, 0);

      // Collision without bypass: pre-write word on B.
      drive(1, 1, 1, 4'hF, 5, 32'h0, 0, 0);
      drive(1, 1, 1, 4'h3, 5, 32'hFFFFFFFF, 1, 5);
      drive(1, 1, 0, 4'h0, 5, 32'h0, 0, 0);

      drive(1, 1, 0, 4'h0, 510, 32'h0, 1, 499);
      idle(1, 2);
      drive(1, 1, 1, 4'hF, 505, 32'hDEAD0505, 1, 500);
      idle(1, 2);
      drive(1, 1, 0, 4'h0, 1, 32'h0, 1, 5);
      idle(1, 4);

      // Reset with reads in flight: nothing may emerge after release.
      ify.a_cs = 1'b1; ify.a_we = 1'b0; ify.a_addr = 9'd2;
      ify.b_cs = 1'b1; ify.b_addr = 9'd3;
      @(negedge clk);
      ify.a_cs = 1'b0; ify.b_cs = 1'b0;
      rst_n_y = 1'b0;
      @(negedge clk);
      rst_n_y = 1'b1;
      repeat (5) @(negedge clk);
      check("y_flight_a_dout", ify.a_dout, 32'h0);
      check("y_flight_b_dout", ify.b_dout, 32'h0);

      check("x_a_drained", qxa.size(), 32'h0);
      check("x_b_drained", qxb.size(), 32'h0);
      check("y_a_drained", qya.size(), 32'h0);
      check("y_b_drained", qyb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
